// File: rtl/dm_arb.sv
// Two-port arbiter for the single-port data memory: round-robin between CPU (port 0)
// and debug (port 1), with a debug exclusive lock and 1-cycle read-return routing.
module dm_arb #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              stall0,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata,
    output logic              locked,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high
    // in a cycle; gnt is a one-cycle acceptance and a new request may follow at once.

    logic last;
    logic lock_held;
    logic rd_pend;
    logic rd_tag;

    logic elig0, elig1;
    logic win0, win1;
    logic rd_issue;

    always_comb begin
        elig0 = req0 & ~lock_held;
        elig1 = req1;
        // On a tie the port that did not win last time goes first.
        win0  = elig0 & (~elig1 | last);
        win1  = elig1 & (~elig0 | ~last);
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        stall0    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata     = '0;
        locked    = 1'b0;
        if (!rst) begin
            gnt0   = win0;
            gnt1   = win1;
            stall0 = req0 & ~win0;
            mem_en = win0 | win1;
            if (win0) begin
                mem_we    = we0;
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end else if (win1) begin
                mem_we    = we1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end
            rvalid0 = rd_pend & ~rd_tag;
            rvalid1 = rd_pend & rd_tag;
            rdata   = rd_pend ? mem_rdata : '0;
            locked  = lock_held;
        end
    end

    assign rd_issue = mem_en & ~mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            lock_held <= 1'b0;
            rd_pend   <= 1'b0;
            rd_tag    <= 1'b0;
        end else begin
            if (gnt0)
                last <= 1'b0;
            else if (gnt1)
                last <= 1'b1;

            // Dropping lock1 always wins; the lock is only taken by a granted debug access.
            if (!lock1)
                lock_held <= 1'b0;
            else if (gnt1)
                lock_held <= 1'b1;

            rd_pend <= rd_issue;
            if (rd_issue)
                rd_tag <= gnt1;
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb: a write-first single-port memory model sits behind the
// arbiter and every check goes through one comparison task.
module tb_dm_arb;

    localparam int WIDTH  = 16;
    localparam int AWIDTH = 8;

    logic              clk;
    logic              rst;
    logic              req0, we0, req1, we1, lock1;
    logic [AWIDTH-1:0] addr0, addr1;
    logic [WIDTH-1:0]  wdata0, wdata1;
    logic              gnt0, gnt1, stall0, rvalid0, rvalid1, locked;
    logic [WIDTH-1:0]  rdata;
    logic              mem_en, mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata, mem_rdata;

    logic [WIDTH-1:0]  mem [0:255];
    logic [WIDTH-1:0]  exp_q[$];

    int checks = 0;
    int errors = 0;

    dm_arb #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .stall0    (stall0),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .locked    (locked),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write-first single-port memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {16'h0, rdata}, {16'h0, e});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        lock1 = 1'b0;
    endtask

    task automatic drive0(input logic we, input logic [AWIDTH-1:0] a, input logic [WIDTH-1:0] d);
        req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic we, input logic [AWIDTH-1:0] a, input logic [WIDTH-1:0] d);
        req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 16'h1234;
        mem[8'h03] = 16'h0003;
        mem[8'h04] = 16'h0004;
        mem_rdata  = '0;
        idle();

        // Reset with requests present: everything gated off
        rst = 1'b1;
        drive0(1'b0, 8'h10, '0);
        drive1(1'b0, 8'h04, '0);
        lock1 = 1'b1;
        sample();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_stall0", stall0, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_locked", locked, 0);
        chk("rst_rdata", rdata, 0);

        // First read after reset
        tick();
        rst = 1'b0;
        idle();
        drive0(1'b0, 8'h10, '0);
        sample();
        chk("t1_gnt0", gnt0, 1);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 8'h10);
        exp_q.push_back(16'h1234);
        tick();
        idle();
        sample();
        chk("t1_rvalid0", rvalid0, 1);
        chk("t1_rvalid1", rvalid1, 0);
        chk_rd("t1_rdata");

        // Fresh reset so the first tie goes to the CPU, then alternate
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive0(1'b1, 8'h01, 16'h1111);
        drive1(1'b1, 8'h02, 16'h2222);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t2_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            chk("t2_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
            chk("t2_stall0", stall0, (i % 2 == 1) ? 1 : 0);
            chk("t2_mem_addr", mem_addr, (i % 2 == 0) ? 8'h01 : 8'h02);
            chk("t2_mem_wdata", mem_wdata, (i % 2 == 0) ? 16'h1111 : 16'h2222);
            chk("t2_mem_we", mem_we, 1);
            tick();
        end

        // Debug lock blocks the CPU until lock1 drops
        idle();
        drive1(1'b1, 8'h20, 16'hBEEF);
        lock1 = 1'b1;
        sample();
        chk("t3_gnt1", gnt1, 1);
        chk("t3_locked_pre", locked, 0);
        chk("t3_wdata", mem_wdata, 16'hBEEF);
        tick();
        idle();
        lock1 = 1'b1;
        drive0(1'b0, 8'h20, '0);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t3_locked", locked, 1);
            chk("t3_gnt0_blk", gnt0, 0);
            chk("t3_stall0_blk", stall0, 1);
            chk("t3_mem_en_blk", mem_en, 0);
            chk("t3_mem_addr_blk", mem_addr, 0);
            tick();
        end
        lock1 = 1'b0;
        sample();
        chk("t3_gnt0_drop", gnt0, 0);
        chk("t3_stall0_drop", stall0, 1);
        tick();
        sample();
        chk("t3_gnt0_after", gnt0, 1);
        chk("t3_stall0_after", stall0, 0);
        chk("t3_locked_after", locked, 0);
        exp_q.push_back(16'hBEEF);
        tick();
        drive0(1'b0, 8'h03, '0);
        lock1 = 1'b1;
        sample();
        chk("t3_lock_no_gnt", gnt0, 1);
        chk("t3_rvalid0", rvalid0, 1);
        chk_rd("t3_rdata_beef");
        exp_q.push_back(16'h0003);
        tick();
        idle();
        sample();
        chk("t3_rvalid0_b", rvalid0, 1);
        chk("t3_rvalid1_b", rvalid1, 0);
        chk("t3_locked_none", locked, 0);
        chk_rd("t3_rdata_3");

        // Back-to-back reads from both ports
        tick();
        drive0(1'b0, 8'h03, '0);
        sample();
        chk("t4_gnt0", gnt0, 1);
        exp_q.push_back(16'h0003);
        tick();
        idle();
        drive1(1'b0, 8'h04, '0);
        sample();
        chk("t4_gnt1", gnt1, 1);
        chk("t4_rvalid0", rvalid0, 1);
        chk_rd("t4_rdata0");
        exp_q.push_back(16'h0004);
        tick();
        idle();
        sample();
        chk("t4_rvalid1", rvalid1, 1);
        chk("t4_rvalid0_off", rvalid0, 0);
        chk_rd("t4_rdata1");

        // Reset with a read in flight drops it
        tick();
        drive0(1'b0, 8'h10, '0);
        sample();
        chk("t5_gnt0", gnt0, 1);
        tick();
        rst = 1'b1;
        idle();
        drive1(1'b0, 8'h04, '0);
        lock1 = 1'b1;
        sample();
        chk("t5_rvalid0_rst", rvalid0, 0);
        chk("t5_rdata_rst", rdata, 0);
        chk("t5_gnt1_rst", gnt1, 0);
        chk("t5_locked_rst", locked, 0);
        tick();
        rst = 1'b0;
        lock1 = 1'b0;
        drive0(1'b0, 8'h10, '0);
        sample();
        chk("t5_tie_gnt0", gnt0, 1);
        chk("t5_tie_gnt1", gnt1, 0);
        chk("t5_rvalid0", rvalid0, 0);
        chk("t5_rvalid1", rvalid1, 0);
        chk("t5_locked", locked, 0);
        exp_q.push_back(16'h1234);

        // Write then read the same address from the other port
        tick();
        drive0(1'b1, 8'h07, 16'hA5A5);
        sample();
        chk("t6_gnt1", gnt1, 1);
        chk("t6_stall0", stall0, 1);
        chk("t6_rvalid0", rvalid0, 1);
        chk_rd("t6_rdata_1234");
        exp_q.push_back(16'h0004);
        tick();
        req1 = 1'b0;
        sample();
        chk("t6_gnt0_wr", gnt0, 1);
        chk("t6_mem_we", mem_we, 1);
        chk("t6_rvalid1", rvalid1, 1);
        chk_rd("t6_rdata_4");
        tick();
        idle();
        drive1(1'b0, 8'h07, '0);
        sample();
        chk("t6_gnt1_rd", gnt1, 1);
        chk("t6_rvalid_wr", rvalid0 | rvalid1, 0);
        exp_q.push_back(16'hA5A5);
        tick();
        idle();
        sample();
        chk("t6_rvalid1_rd", rvalid1, 1);
        chk_rd("t6_rdata_a5a5");

        chk("q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arb.md
Name: dm_arb

Overview:
- Two-requester arbiter and sequencer for the processor's single-port data memory.
- Port 0 is the CPU load/store path: the decoder's dms/dmwe after address computation by the ALU.
- Port 1 is the debug/loader port, used to preload and inspect memory and to hold the CPU off memory while it does so.
- Issues at most one memory access per cycle, routes 1-cycle-latency read data back to the correct requester, and generates the CPU stall.

Parameters:
WIDTH, 16, data word width (matches datapath word)
AWIDTH, 8, data memory address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  CPU access request
we0  in  1  CPU write enable (1 = store, 0 = load)
addr0  in  AWIDTH  CPU address
wdata0  in  WIDTH  CPU store data
req1  in  1  debug access request
we1  in  1  debug write enable
addr1  in  AWIDTH  debug address
wdata1  in  WIDTH  debug write data
lock1  in  1  debug exclusive-access request
gnt0  out  1  CPU access accepted this cycle
gnt1  out  1  debug access accepted this cycle
stall0  out  1  CPU must hold its instruction (req0 & ~gnt0)
rvalid0  out  1  rdata holds CPU read result
rvalid1  out  1  rdata holds debug read result
rdata  out  WIDTH  read data
locked  out  1  exclusive lock currently held by debug
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AWIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data, valid the cycle after a read strobe

Behaviour:
- State registers:
  - last (last granted port; reset value 1, so the CPU wins the first tie).
  - lock_held (reset 0).
  - rd_pend (reset 0).
  - rd_tag (reset 0).
- While rst is high:
  - Every output is 0, including gnt*, stall0 and the mem_* outputs.
  - Combinational outputs are gated by rst.
- Arbitration is combinational within the same cycle:
  - Eligibility: elig0 = req0 & ~lock_held; elig1 = req1.
  - Only one port eligible: that port is granted.
  - Both eligible: grant the port != last (round robin).
  - At most one gnt is high per cycle.
- Requester handshake:
  - Requester holds req, we, addr and wdata stable until it sees gnt high in a cycle.
  - gnt is a 1-cycle acceptance.
  - A requester may present a new request in the cycle after its grant.
- Issue:
  - mem_en = gnt0 | gnt1.
  - mem_we, mem_addr and mem_wdata are the granted port's signals.
  - With no grant, mem_we, mem_addr and mem_wdata are 0.
  - Writes complete in the grant cycle; there is no response.
- On each grant, last <= granted port.
- Read return:
  - A read grant (mem_en & ~mem_we) sets rd_pend <= 1 and rd_tag <= port; otherwise rd_pend <= 0.
  - In the next cycle, rvalid[rd_tag] = rd_pend and rdata = mem_rdata.
  - When rd_pend = 0, rdata = 0.
  - Reads may issue back-to-back; each rvalid follows its grant by exactly 1 cycle.
  - A new grant in the rvalid cycle is allowed.
- Lock:
  - lock_held <= 1 on a gnt1 cycle with lock1 = 1.
  - lock_held <= 0 in any cycle where lock1 = 0.
  - locked = lock_held.
  - While locked, CPU requests are never granted and stall0 follows req0.
  - lock1 asserted without a debug grant does not block the CPU.
- stall0 = req0 & ~gnt0. The CPU pipeline uses it to freeze the PC and the register write.
- A CPU load is not stalled waiting for rvalid0; the datapath samples rdata on rvalid0.
- Reset mid-operation:
  - A pending read is dropped: no rvalid after reset release.
  - lock is released.
  - last returns to 1.
- Same-address write followed by read on the next cycle returns the new data (the memory's write-first behaviour is relied on; the arbiter does no forwarding).

Test Plan:
- Reset release, req0=1, we0=0, addr0=8'h10, memory[16'h10]=16'h1234:
  - gnt0=1, mem_en=1, mem_we=0 in the grant cycle.
  - Next cycle rvalid0=1, rdata=16'h1234, rvalid1=0.
- req0 and req1 both held high for 4 cycles (writes, addrs 1 and 2):
  - Grants go 0,1,0,1.
  - stall0 = 1 in cycles 2 and 4.
  - mem_addr sequence 1,2,1,2.
- lock1=1, req1 write addr 8'h20 data 16'hBEEF granted, then req0 read:
  - locked=1; gnt0=0 and stall0=1 for as long as lock1 is held.
  - After lock1 drops, the CPU is granted the next cycle.
- Back-to-back reads, CPU addr 3 then debug addr 4 (data 16'h0003, 16'h0004):
  - rvalid0 with 16'h0003, then rvalid1 with 16'h0004 on consecutive cycles.
- Read granted, rst asserted the following cycle then released:
  - rvalid0 and rvalid1 stay 0 throughout; locked=0.
  - First tie after release goes to the CPU.
- Write 16'hA5A5 to addr 7 (port 0), read addr 7 the next cycle (port 1):
  - rvalid1=1, rdata=16'hA5A5.
